xo_decode_stage: RTL and testbench
==================================

# xo_decode_stage

Pipelined, parametrised XO-form decode stage for the POWER ISA 3.0B front end. It accepts one instruction per cycle under a valid/stall handshake and classifies primary-opcode-31 XO-form arithmetic ops. It flags reserved-field and illegal-OE encodings and routes them to the trap unit. Decoded micro-ops sit in a small output FIFO, so downstream back-pressure never drops work; the stage sits between fetch and dispatch.

## Interface
- opcodeWidth, 6, primary opcode field width
- xOpCodeWidth, 9, extended opcode width (bits 22..30)
- regWidth, 5, register specifier width
- instructionWidth, 32, instruction word width
- addressWidth, 64, instruction address width
- fuCodeWidth, 3, functional-unit code width
- bufferDepth, 4, output FIFO entries (power of two, ≥2)
- FXUnitCode, 0, fixed-point unit ID
- TrapUnitCode, 4, trap unit ID

Ports:
- clock_i  in  1  clock
- reset_i  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous pipeline flush
- enable_i  in  1  input instruction valid
- instruction_i  in  instructionWidth  instruction word, big-endian bit numbering
- address_i  in  addressWidth  instruction address
- stall_o  out  1  stage cannot accept (FIFO full)
- ready_i  in  1  dispatch accepts head entry
- enable_o  out  1  head entry valid
- reg1_o, reg2_o, reg3_o  out  regWidth each  RT, RA, RB
- xOpCode_o  out  xOpCodeWidth  extended opcode
- oe_o, rc_o  out  1 each  bit 21 (OE), bit 31 (Rc)
- functionalUnitCode_o  out  fuCodeWidth  target unit
- illegal_o  out  1  illegal encoding, route to trap
- address_o  out  addressWidth  address of head entry

## Operation
- Push when enable_i=1, stall_o=0 and flush_i=0. A push occurs only if the opcode is 31 and xOpCode is one of the 26 XO values: 266, 40, 10, 8, 138, 136, 234, 232, 200, 202, 104, 235, 75, 11, 491, 459, 427, 395, 233, 73, 9, 489, 457, 425, 393, 74.
- Other opcode-31 words and non-31 words are consumed with no entry. Sibling decoders claim them.
- Legal entry: functionalUnitCode = FXUnitCode, illegal = 0.
- Illegal entry: illegal = 1, functionalUnitCode = TrapUnitCode, all fields still captured. An entry is illegal if either:
  - OE=1 on a no-OE op (75, 11, 73, 9, 74);
  - RB≠0 on a single-operand op (104, 234, 232, 200, 202).
- Pop when enable_o=1 and ready_i=1.
- FIFO: write/read pointers wrap modulo bufferDepth. Occupancy count is 0..bufferDepth.
- stall_o = (count == bufferDepth), registered.
- Full with a pop in the same cycle: the pop happens, the push is refused, and stall_o falls on the next cycle.
- Empty with a push in the same cycle: the entry appears the next cycle. There is no same-cycle bypass.
- flush_i clears pointers and count and drops the same-cycle push and pop. enable_o=0 and stall_o=0 next cycle.
- Reset (any time, mid-operation): all outputs 0, pointers and count 0, FIFO contents don't-care.

## Timing
- Latency: an accepted instruction reaches the head one cycle after acceptance, provided the FIFO is empty.
- Throughput: 1 instruction/cycle while not full.
- Head outputs are stable while enable_o=1 and ready_i=0.
- Every output is driven from registered state.

## Structure
- Package xo_decode_pkg holds:
  - localparams for all 26 XO xOpCode values;
  - FX and Trap unit codes;
  - the no-OE and single-operand op masks;
  - a packed struct for the decoded entry.
- Sub-module decode_fifo: a generic parametrised synchronous FIFO (push/pop/flush, full/empty, count) holding the entry struct. The top module holds the classify logic.

## Test plan
- 0x7C642A14 (add r3,r4,r5), ready_i=1 → one cycle later: enable_o=1, regs 3/4/5, xOpCode 266, oe=0, rc=0, FU=0, illegal=0.
- 0x7C221C16 (mulhwu with OE=1) → illegal=1, FU=4, xOpCode 11, oe=1.
- 0x7C6408D0 (neg, RB=1) → illegal=1, FU=4. Then 0x7C6400D0 → illegal=0, FU=0.
- 0x7C0004AC (sync) and 0x38600001 (addi) → no entry, enable_o stays 0, stall_o stays 0.
- ready_i=0, push 4 × add → stall_o=1 after the 4th; a 5th enable_i is refused. Raise ready_i → entries drain in order. stall_o=0 the cycle after the first pop.
- FIFO holding 2 entries: assert flush_i → enable_o=0 next cycle. Assert reset_i low mid-burst → all outputs 0 immediately, and the stage accepts again after release.

Source files
------------

// File: rtl/xo_decode_pkg.sv
// Shared definitions for the XO-form decode stage.
//   - Field widths of the POWER XO-form instruction word.
//   - The 26 recognised XO extended-opcode values (primary opcode 31).
//   - Functional-unit codes for the fixed-point and trap units.
//   - Opcode membership masks, each indexed by the 9-bit extended opcode:
//     every recognised XO op, ops with no OE variant, and single-operand ops.
//   - Packed struct describing one decoded FIFO entry.
package xo_decode_pkg;

    localparam int OPCODE_W = 6;
    localparam int XOP_W    = 9;
    localparam int REG_W    = 5;
    localparam int INSTR_W  = 32;
    localparam int ADDR_W   = 64;
    localparam int FU_W     = 3;

    localparam logic [OPCODE_W-1:0] PRIMARY_OP_XO = 6'd31;

    localparam logic [FU_W-1:0] FX_UNIT_CODE   = 3'd0;
    localparam logic [FU_W-1:0] TRAP_UNIT_CODE = 3'd4;

    // Recognised XO-form extended opcodes
    localparam logic [XOP_W-1:0] XO_ADD    = 9'd266;
    localparam logic [XOP_W-1:0] XO_SUBF   = 9'd40;
    localparam logic [XOP_W-1:0] XO_ADDC   = 9'd10;
    localparam logic [XOP_W-1:0] XO_SUBFC  = 9'd8;
    localparam logic [XOP_W-1:0] XO_ADDE   = 9'd138;
    localparam logic [XOP_W-1:0] XO_SUBFE  = 9'd136;
    localparam logic [XOP_W-1:0] XO_ADDME  = 9'd234;
    localparam logic [XOP_W-1:0] XO_SUBFME = 9'd232;
    localparam logic [XOP_W-1:0] XO_SUBFZE = 9'd200;
    localparam logic [XOP_W-1:0] XO_ADDZE  = 9'd202;
    localparam logic [XOP_W-1:0] XO_NEG    = 9'd104;
    localparam logic [XOP_W-1:0] XO_MULLW  = 9'd235;
    localparam logic [XOP_W-1:0] XO_MULHW  = 9'd75;
    localparam logic [XOP_W-1:0] XO_MULHWU = 9'd11;
    localparam logic [XOP_W-1:0] XO_DIVW   = 9'd491;
    localparam logic [XOP_W-1:0] XO_DIVWU  = 9'd459;
    localparam logic [XOP_W-1:0] XO_DIVWE  = 9'd427;
    localparam logic [XOP_W-1:0] XO_DIVWEU = 9'd395;
    localparam logic [XOP_W-1:0] XO_MULLD  = 9'd233;
    localparam logic [XOP_W-1:0] XO_MULHD  = 9'd73;
    localparam logic [XOP_W-1:0] XO_MULHDU = 9'd9;
    localparam logic [XOP_W-1:0] XO_DIVD   = 9'd489;
    localparam logic [XOP_W-1:0] XO_DIVDU  = 9'd457;
    localparam logic [XOP_W-1:0] XO_DIVDE  = 9'd425;
    localparam logic [XOP_W-1:0] XO_DIVDEU = 9'd393;
    localparam logic [XOP_W-1:0] XO_ADDG6S = 9'd74;

    localparam int MASK_W = 1 << XOP_W;

    localparam logic [MASK_W-1:0] XO_OP_MASK =
        (512'd1 << XO_ADD)    | (512'd1 << XO_SUBF)   | (512'd1 << XO_ADDC)   |
        (512'd1 << XO_SUBFC)  | (512'd1 << XO_ADDE)   | (512'd1 << XO_SUBFE)  |
        (512'd1 << XO_ADDME)  | (512'd1 << XO_SUBFME) | (512'd1 << XO_SUBFZE) |
        (512'd1 << XO_ADDZE)  | (512'd1 << XO_NEG)    | (512'd1 << XO_MULLW)  |
        (512'd1 << XO_MULHW)  | (512'd1 << XO_MULHWU) | (512'd1 << XO_DIVW)   |
        (512'd1 << XO_DIVWU)  | (512'd1 << XO_DIVWE)  | (512'd1 << XO_DIVWEU) |
        (512'd1 << XO_MULLD)  | (512'd1 << XO_MULHD)  | (512'd1 << XO_MULHDU) |
        (512'd1 << XO_DIVD)   | (512'd1 << XO_DIVDU)  | (512'd1 << XO_DIVDE)  |
        (512'd1 << XO_DIVDEU) | (512'd1 << XO_ADDG6S);

    // High-half multiplies and addg6s have no overflow-enable form
    localparam logic [MASK_W-1:0] NO_OE_MASK =
        (512'd1 << XO_MULHW) | (512'd1 << XO_MULHWU) | (512'd1 << XO_MULHD) |
        (512'd1 << XO_MULHDU) | (512'd1 << XO_ADDG6S);

    // Single-operand ops leave the RB field reserved (must be zero)
    localparam logic [MASK_W-1:0] SINGLE_OP_MASK =
        (512'd1 << XO_NEG) | (512'd1 << XO_ADDME) | (512'd1 << XO_SUBFME) |
        (512'd1 << XO_SUBFZE) | (512'd1 << XO_ADDZE);

    typedef struct packed {
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  ra;
        logic [REG_W-1:0]  rb;
        logic [XOP_W-1:0]  xop;
        logic              oe;
        logic              rc;
        logic [FU_W-1:0]   fu;
        logic              illegal;
        logic [ADDR_W-1:0] addr;
    } xo_entry_t;

endpackage

// File: rtl/decode_fifo.sv
// Generic synchronous FIFO for decoded micro-ops.
//   clock_i, reset_i (async, active-low), flush_i (sync clear)
//   push_i / data_i : write request and payload (ignored while full)
//   pop_i           : read request (ignored while empty)
//   data_o          : head entry (meaningful only while empty_o = 0)
//   full_o, empty_o : registered occupancy flags
// Control state is reset; the storage array is not.
module decode_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic flush_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    always_comb begin
        // A full FIFO refuses a push even when a pop frees a slot this cycle
        do_push  = push_i & ~full_q & ~flush_i;
        do_pop   = pop_i & ~empty_q & ~flush_i;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/xo_decode_stage.sv
// XO-form decode stage: classifies primary-opcode-31 XO arithmetic ops and
// queues decoded micro-ops for dispatch.
//   clock_i, reset_i (async, active-low), flush_i (sync)
//   enable_i, instruction_i, address_i : incoming instruction
//   stall_o                            : stage full, input not accepted
//   ready_i                            : dispatch takes the head entry
//   enable_o and head fields           : reg1/2/3 (RT/RA/RB), xOpCode, oe, rc,
//                                        functionalUnitCode, illegal, address
// Words that are not recognised XO ops are consumed without an entry.
module xo_decode_stage
    import xo_decode_pkg::*;
#(
    parameter int opcodeWidth      = OPCODE_W,
    parameter int xOpCodeWidth     = XOP_W,
    parameter int regWidth         = REG_W,
    parameter int instructionWidth = INSTR_W,
    parameter int addressWidth     = ADDR_W,
    parameter int fuCodeWidth      = FU_W,
    parameter int bufferDepth      = 4,
    parameter logic [fuCodeWidth-1:0] FXUnitCode   = FX_UNIT_CODE,
    parameter logic [fuCodeWidth-1:0] TrapUnitCode = TRAP_UNIT_CODE
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        flush_i,
    input  logic                        enable_i,
    input  logic [instructionWidth-1:0] instruction_i,
    input  logic [addressWidth-1:0]     address_i,
    output logic                        stall_o,
    input  logic                        ready_i,
    output logic                        enable_o,
    output logic [regWidth-1:0]         reg1_o,
    output logic [regWidth-1:0]         reg2_o,
    output logic [regWidth-1:0]         reg3_o,
    output logic [xOpCodeWidth-1:0]     xOpCode_o,
    output logic                        oe_o,
    output logic                        rc_o,
    output logic [fuCodeWidth-1:0]      functionalUnitCode_o,
    output logic                        illegal_o,
    output logic [addressWidth-1:0]     address_o
);

    // Big-endian bit i of the ISA is little-endian bit (instructionWidth-1-i)
    localparam int RT_MSB = instructionWidth - 1 - opcodeWidth;
    localparam int RA_MSB = RT_MSB - regWidth;
    localparam int RB_MSB = RA_MSB - regWidth;

    logic [opcodeWidth-1:0]  opcode;
    logic [xOpCodeWidth-1:0] xop;
    logic [regWidth-1:0]     rt, ra, rb;
    logic                    oe, rc;
    logic                    is_xo_op, bad_oe, bad_rb;
    logic                    push;
    xo_entry_t               entry_d;
    xo_entry_t               head;
    logic                    fifo_full, fifo_empty;

    always_comb begin
        opcode = instruction_i[instructionWidth-1 -: opcodeWidth];
        rt     = instruction_i[RT_MSB -: regWidth];
        ra     = instruction_i[RA_MSB -: regWidth];
        rb     = instruction_i[RB_MSB -: regWidth];
        oe     = instruction_i[xOpCodeWidth+1];
        xop    = instruction_i[xOpCodeWidth:1];
        rc     = instruction_i[0];

        is_xo_op = (opcode == PRIMARY_OP_XO) && XO_OP_MASK[xop];
        bad_oe   = NO_OE_MASK[xop] & oe;
        bad_rb   = SINGLE_OP_MASK[xop] & (rb != '0);

        // Illegal encodings still carry every field so the trap unit can report them
        entry_d         = '0;
        entry_d.rt      = rt;
        entry_d.ra      = ra;
        entry_d.rb      = rb;
        entry_d.xop     = xop;
        entry_d.oe      = oe;
        entry_d.rc      = rc;
        entry_d.illegal = bad_oe | bad_rb;
        entry_d.fu      = (bad_oe | bad_rb) ? TrapUnitCode : FXUnitCode;
        entry_d.addr    = address_i;

        push = enable_i & ~fifo_full & ~flush_i & is_xo_op;
    end

    decode_fifo #(
        .DEPTH (bufferDepth),
        .T     (xo_entry_t)
    ) u_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  (entry_d),
        .pop_i   (enable_o & ready_i),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Storage is not reset, so head fields are forced to zero while empty
    always_comb begin
        stall_o              = fifo_full;
        enable_o             = ~fifo_empty;
        reg1_o               = fifo_empty ? '0 : head.rt;
        reg2_o               = fifo_empty ? '0 : head.ra;
        reg3_o               = fifo_empty ? '0 : head.rb;
        xOpCode_o            = fifo_empty ? '0 : head.xop;
        oe_o                 = fifo_empty ? 1'b0 : head.oe;
        rc_o                 = fifo_empty ? 1'b0 : head.rc;
        functionalUnitCode_o = fifo_empty ? '0 : head.fu;
        illegal_o            = fifo_empty ? 1'b0 : head.illegal;
        address_o            = fifo_empty ? '0 : head.addr;
    end

endmodule

// File: tb/tb_xo_decode_stage.sv
module tb_xo_decode_stage;

    localparam int DEPTH = 4;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        enable_i = 1'b0;
    logic [31:0] instruction_i = '0;
    logic [63:0] address_i = '0;
    logic        ready_i = 1'b0;
    logic        stall_o, enable_o, oe_o, rc_o, illegal_o;
    logic [4:0]  reg1_o, reg2_o, reg3_o;
    logic [8:0]  xOpCode_o;
    logic [2:0]  functionalUnitCode_o;
    logic [63:0] address_o;

    xo_decode_stage dut (
        .clock_i              (clock_i),
        .reset_i              (reset_i),
        .flush_i              (flush_i),
        .enable_i             (enable_i),
        .instruction_i        (instruction_i),
        .address_i            (address_i),
        .stall_o              (stall_o),
        .ready_i              (ready_i),
        .enable_o             (enable_o),
        .reg1_o               (reg1_o),
        .reg2_o               (reg2_o),
        .reg3_o               (reg3_o),
        .xOpCode_o            (xOpCode_o),
        .oe_o                 (oe_o),
        .rc_o                 (rc_o),
        .functionalUnitCode_o (functionalUnitCode_o),
        .illegal_o            (illegal_o),
        .address_o            (address_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct {
        logic [4:0]  rt, ra, rb;
        logic [8:0]  xop;
        logic        oe, rc;
        logic [2:0]  fu;
        logic        ill;
        logic [63:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_pops = 0;

    int XO_LIST [26] = '{266, 40, 10, 8, 138, 136, 234, 232, 200, 202, 104, 235, 75,
                         11, 491, 459, 427, 395, 233, 73, 9, 489, 457, 425, 393, 74};
    int NOOE_LIST [5]   = '{75, 11, 73, 9, 74};
    int SINGLE_LIST [5] = '{104, 234, 232, 200, 202};

    function automatic bit in_xo(input int v);
        foreach (XO_LIST[i]) if (XO_LIST[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_noe(input int v);
        foreach (NOOE_LIST[i]) if (NOOE_LIST[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit in_single(input int v);
        foreach (SINGLE_LIST[i]) if (SINGLE_LIST[i] == v) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit claims(input logic [31:0] w);
        int op, xo;
        op = int'((w >> 26) & 32'd63);
        xo = int'((w >> 1) & 32'd511);
        return (op == 31) && in_xo(xo);
    endfunction

    // Reference decode straight from the ISA field layout
    function automatic exp_t model(input logic [31:0] w, input logic [63:0] a);
        exp_t e;
        int   xo;
        xo     = int'((w >> 1) & 32'd511);
        e.rt   = 5'((w >> 21) & 32'd31);
        e.ra   = 5'((w >> 16) & 32'd31);
        e.rb   = 5'((w >> 11) & 32'd31);
        e.xop  = 9'(xo);
        e.oe   = 1'((w >> 10) & 32'd1);
        e.rc   = 1'(w & 32'd1);
        e.ill  = (in_noe(xo) && e.oe) || (in_single(xo) && e.rb != 0);
        e.fu   = e.ill ? 3'd4 : 3'd0;
        e.addr = a;
        return e;
    endfunction

    function automatic logic [93:0] pack_exp(input exp_t e);
        return {e.rt, e.ra, e.rb, e.xop, e.oe, e.rc, e.fu, e.ill, e.addr};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [95:0] all_outs();
        return {enable_o, stall_o, reg1_o, reg2_o, reg3_o, xOpCode_o, oe_o, rc_o,
                functionalUnitCode_o, illegal_o, address_o};
    endfunction

    // Monitor: compares the presented head with the scoreboard and retires on handshake
    always @(negedge clock_i) begin
        if (!reset_i) begin
            chk("reset_outputs", 128'(all_outs()), 128'd0);
        end else begin
            chk("enable_o", 128'(enable_o), 128'(exp_q.size() != 0));
            chk("stall_o", 128'(stall_o), 128'(exp_q.size() == DEPTH));
            if (exp_q.size() != 0) begin
                chk("head_entry",
                    128'({reg1_o, reg2_o, reg3_o, xOpCode_o, oe_o, rc_o,
                          functionalUnitCode_o, illegal_o, address_o}),
                    128'(pack_exp(exp_q[0])));
                if (ready_i && !flush_i) begin
                    void'(exp_q.pop_front());
                    n_pops++;
                end
            end
        end
    end

    // Driver: one cycle of stimulus; the expected entry is queued at the accepting edge
    task automatic step(input logic en, input logic [31:0] w, input logic [63:0] a,
                        input logic rdy, input logic fl);
        bit acc;
        enable_i      = en;
        instruction_i = w;
        address_i     = a;
        ready_i       = rdy;
        flush_i       = fl;
        acc = en && !fl && (exp_q.size() < DEPTH) && claims(w);
        @(posedge clock_i);
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back(model(w, a));
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 64'h0, rdy, 1'b0);
    endtask

    function automatic logic [31:0] rand_instr();
        int         k, x, op;
        logic [8:0] xv;
        logic [5:0] ov;
        logic [4:0] rbv;
        k = $urandom_range(0, 9);
        if (k < 6) begin
            x   = XO_LIST[$urandom_range(0, 25)];
            xv  = 9'(x);
            rbv = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom);
            return {6'd31, 5'($urandom), 5'($urandom), rbv, 1'($urandom), xv, 1'($urandom)};
        end else if (k < 8) begin
            do x = $urandom_range(0, 511); while (in_xo(x));
            xv = 9'(x);
            return {6'd31, 15'($urandom), 1'($urandom), xv, 1'($urandom)};
        end else begin
            do op = $urandom_range(0, 63); while (op == 31);
            ov = 6'(op);
            return {ov, 26'($urandom)};
        end
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        #1 reset_i = 1'b0;
        repeat (3) @(posedge clock_i);
        #2 reset_i = 1'b1;
        @(posedge clock_i);
        #1;

        // add r3,r4,r5
        step(1'b1, 32'h7C642A14, 64'h1000, 1'b1, 1'b0);
        chk("add_fields", 128'({enable_o, reg1_o, reg2_o, reg3_o, xOpCode_o, oe_o, rc_o,
                                functionalUnitCode_o, illegal_o}),
            128'({1'b1, 5'd3, 5'd4, 5'd5, 9'd266, 1'b0, 1'b0, 3'd0, 1'b0}));
        idle(1, 1'b1);

        // mulhwu with OE=1
        step(1'b1, 32'h7C221C16, 64'h1004, 1'b1, 1'b0);
        chk("mulhwu_oe", 128'({illegal_o, functionalUnitCode_o, xOpCode_o, oe_o}),
            128'({1'b1, 3'd4, 9'd11, 1'b1}));
        // neg with RB=1, then legal neg
        step(1'b1, 32'h7C6408D0, 64'h1008, 1'b1, 1'b0);
        chk("neg_rb1", 128'({illegal_o, functionalUnitCode_o}), 128'({1'b1, 3'd4}));
        step(1'b1, 32'h7C6400D0, 64'h100C, 1'b1, 1'b0);
        chk("neg_rb0", 128'({illegal_o, functionalUnitCode_o}), 128'({1'b0, 3'd0}));
        idle(1, 1'b1);

        // sync and addi are claimed elsewhere
        step(1'b1, 32'h7C0004AC, 64'h1010, 1'b1, 1'b0);
        step(1'b1, 32'h38600001, 64'h1014, 1'b1, 1'b0);
        chk("no_entry", 128'({enable_o, stall_o}), 128'd0);

        // Fill to full, refuse a fifth, then drain in order
        for (int i = 0; i < 4; i++) step(1'b1, 32'h7C642A14, 64'h2000 + 64'(i), 1'b0, 1'b0);
        chk("stall_full", 128'(stall_o), 128'd1);
        step(1'b1, 32'h7C642A14, 64'h2004, 1'b0, 1'b0);
        step(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        chk("stall_after_pop", 128'(stall_o), 128'd0);
        idle(6, 1'b1);

        // Full with simultaneous pop and push: push refused
        for (int i = 0; i < 4; i++) step(1'b1, 32'h7C642A14, 64'h3000 + 64'(i), 1'b0, 1'b0);
        step(1'b1, 32'h7C642A14, 64'h3004, 1'b1, 1'b0);
        idle(6, 1'b1);

        // Flush with two entries held
        step(1'b1, 32'h7C642A14, 64'h4000, 1'b0, 1'b0);
        step(1'b1, 32'h7C642A14, 64'h4001, 1'b0, 1'b0);
        step(1'b1, 32'h7C642A14, 64'h4002, 1'b1, 1'b1);
        chk("flush_clears", 128'({enable_o, stall_o}), 128'd0);
        idle(2, 1'b1);

        // Asynchronous reset mid-burst
        step(1'b1, 32'h7C642A14, 64'h5000, 1'b0, 1'b0);
        step(1'b1, 32'h7C642A14, 64'h5001, 1'b0, 1'b0);
        #2 reset_i = 1'b0;
        exp_q.delete();
        #1 chk("reset_async", 128'(all_outs()), 128'd0);
        enable_i = 1'b0;
        ready_i  = 1'b0;
        repeat (2) @(posedge clock_i);
        #2 reset_i = 1'b1;
        @(posedge clock_i);
        #1;
        step(1'b1, 32'h7C642A14, 64'h5100, 1'b1, 1'b0);
        chk("accept_after_reset", 128'({enable_o, address_o}), 128'({1'b1, 64'h5100}));
        idle(2, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 9) < 7, rand_instr(), {$urandom, $urandom},
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 2);
        end
        idle(8, 1'b1);

        n_cmp++;
        if (n_pops < 200) begin
            n_bad++;
            $display("FAIL retired_count: got %0d expected at least 200", n_pops);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
